// File: rtl/z80_snd_responder.sv
// Sound-Z80 bus responder: host command latch with IRQ, status register and
// wait-state insertion for a slow memory-mapped region.
module z80_snd_responder #(
    parameter logic [15:0] LATCH_ADDR  = 16'hA000,
    parameter logic [15:0] STATUS_ADDR = 16'hA001,
    parameter logic [15:0] IRQCLR_ADDR = 16'hB000,
    parameter logic [15:0] SLOW_BASE   = 16'hC000,
    parameter logic [15:0] SLOW_MASK   = 16'hF000,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic [15:0] Z80_ADDR,
    input  logic [7:0]  Z80_DOUT,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    output logic [7:0]  Z80_DIN,
    output logic        nWAIT,
    output logic        nINT,
    input  logic        CMD_WR,
    input  logic [7:0]  CMD_DATA,
    input  logic [7:0]  MEM_DOUT
);

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        rd_q, wr_q;
    logic [7:0]  latch_q;
    logic        pending_q, overrun_q, nint_q;

    logic        rd_act, wr_act, rd_ev, wr_ev;
    logic        slow, start_wait, clr_rd, clr_wr;

    // Write data is irrelevant: any write to the clear address acknowledges.
    logic        unused_dout;
    assign unused_dout = ^Z80_DOUT;

    assign rd_act     = ~nMREQ & ~nRD & nIORQ;
    assign wr_act     = ~nMREQ & ~nWR & nIORQ;
    assign rd_ev      = rd_act & ~rd_q;
    assign wr_ev      = wr_act & ~wr_q;
    assign slow       = (Z80_ADDR & SLOW_MASK) == SLOW_BASE;
    assign start_wait = (rd_ev | wr_ev) & slow;
    assign clr_rd     = rd_ev & (Z80_ADDR == LATCH_ADDR);
    assign clr_wr     = wr_ev & (Z80_ADDR == IRQCLR_ADDR);

    always_ff @(posedge clk) begin
        // Strobe history runs through reset so a held strobe cannot re-trigger.
        rd_q <= rd_act;
        wr_q <= wr_act;
        if (!nRESET) begin
            latch_q   <= 8'h00;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            nint_q    <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
        end else begin
            if (CMD_WR) begin
                latch_q   <= CMD_DATA;
                pending_q <= 1'b1;
                nint_q    <= 1'b0;
                if (pending_q) overrun_q <= 1'b1;
            end else begin
                if (clr_rd || clr_wr) begin
                    pending_q <= 1'b0;
                    nint_q    <= 1'b1;
                end
                if (clr_wr) overrun_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (start_wait) begin
                        cnt_q   <= WaitInit;
                        state_q <= (WAIT_CYCLES == 1) ? StHold : StWait;
                    end
                end
                StWait: begin
                    if (nMREQ)               state_q <= StIdle;
                    else if (cnt_q == 4'd1)  state_q <= StHold;
                    else                     cnt_q   <= cnt_q - 4'd1;
                end
                StHold: begin
                    if (nMREQ) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The strobe clock itself counts as the first wait clock.
    always_comb begin
        nWAIT = 1'b1;
        case (state_q)
            StIdle:  nWAIT = ~start_wait;
            StWait:  nWAIT = nMREQ;
            default: nWAIT = 1'b1;
        endcase
    end

    always_comb begin
        Z80_DIN = MEM_DOUT;
        if (Z80_ADDR == LATCH_ADDR)       Z80_DIN = latch_q;
        else if (Z80_ADDR == STATUS_ADDR) Z80_DIN = {6'b0, overrun_q, pending_q};
    end

    assign nINT = nint_q;

endmodule

// File: tb/tb_z80_snd_responder.sv
// Directed plus randomized bench for z80_snd_responder against a
// transaction-level model of the latch/IRQ/status and wait-length rules.
module tb_z80_snd_responder;

    localparam logic [15:0] LATCH_A  = 16'hA000;
    localparam logic [15:0] STATUS_A = 16'hA001;
    localparam logic [15:0] IRQCLR_A = 16'hB000;
    localparam int          WAITS    = 3;

    logic        clk = 1'b0;
    logic        nRESET;
    logic [15:0] Z80_ADDR;
    logic [7:0]  Z80_DOUT;
    logic        nMREQ, nIORQ, nRD, nWR;
    logic [7:0]  Z80_DIN;
    logic        nWAIT, nINT;
    logic        CMD_WR;
    logic [7:0]  CMD_DATA;
    logic [7:0]  MEM_DOUT;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [7:0] m_latch;
    logic       m_pending, m_overrun;

    z80_snd_responder dut (
        .clk      (clk),
        .nRESET   (nRESET),
        .Z80_ADDR (Z80_ADDR),
        .Z80_DOUT (Z80_DOUT),
        .nMREQ    (nMREQ),
        .nIORQ    (nIORQ),
        .nRD      (nRD),
        .nWR      (nWR),
        .Z80_DIN  (Z80_DIN),
        .nWAIT    (nWAIT),
        .nINT     (nINT),
        .CMD_WR   (CMD_WR),
        .CMD_DATA (CMD_DATA),
        .MEM_DOUT (MEM_DOUT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 2ns later.
    task automatic step();
        @(negedge clk);
        MEM_DOUT = 8'($urandom);
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic bus_idle();
        nMREQ  = 1'b1;
        nRD    = 1'b1;
        nWR    = 1'b1;
        nIORQ  = 1'b1;
        CMD_WR = 1'b0;
    endtask

    function automatic logic [7:0] exp_din(input logic [15:0] a);
        if (a == LATCH_A)  return m_latch;
        if (a == STATUS_A) return {6'b0, m_overrun, m_pending};
        return MEM_DOUT;
    endfunction

    function automatic void m_cmd(input logic [7:0] d);
        if (m_pending) m_overrun = 1'b1;
        m_latch   = d;
        m_pending = 1'b1;
    endfunction

    function automatic void m_reset();
        m_latch   = 8'h00;
        m_pending = 1'b0;
        m_overrun = 1'b0;
    endfunction

    task automatic host_cmd(input logic [7:0] d);
        step(); bus_idle();
        CMD_WR = 1'b1; CMD_DATA = d;
        settle();
        m_cmd(d);
        step(); CMD_WR = 1'b0;
        settle();
        chk("nint_after_cmd", {15'b0, nINT}, 16'h0000);
    endtask

    // Fast read, optionally with a host command landing on the strobe clock.
    task automatic fast_read(input logic [15:0] a, input logic cmd_en, input logic [7:0] cmd_b);
        step(); bus_idle();
        Z80_ADDR = a; nMREQ = 1'b0; nRD = 1'b0;
        CMD_WR = cmd_en; CMD_DATA = cmd_b;
        settle();
        chk("read_data", {8'h00, Z80_DIN}, {8'h00, exp_din(a)});
        chk("read_nwait", {15'b0, nWAIT}, 16'h0001);
        if (cmd_en) m_cmd(cmd_b);
        else if (a == LATCH_A) m_pending = 1'b0;
        step(); CMD_WR = 1'b0;
        settle();
        chk("read_nint", {15'b0, nINT}, {15'b0, ~m_pending});
        step(); bus_idle();
        settle();
    endtask

    task automatic fast_write(input logic [15:0] a, input logic [7:0] d);
        step(); bus_idle();
        Z80_ADDR = a; Z80_DOUT = d; nMREQ = 1'b0;
        settle();
        step(); nWR = 1'b0;
        settle();
        chk("write_nwait", {15'b0, nWAIT}, 16'h0001);
        if (a == IRQCLR_A) begin
            m_pending = 1'b0;
            m_overrun = 1'b0;
        end
        step(); bus_idle();
        settle();
        chk("write_nint", {15'b0, nINT}, {15'b0, ~m_pending});
    endtask

    task automatic slow_access(input logic is_wr, input logic [15:0] a);
        int n;
        step(); bus_idle();
        Z80_ADDR = a; nMREQ = 1'b0;
        if (!is_wr) nRD = 1'b0;
        settle();
        if (is_wr) begin
            chk("slow_prewr_nwait", {15'b0, nWAIT}, 16'h0001);
            step(); nWR = 1'b0; Z80_DOUT = 8'($urandom);
            settle();
        end
        n = 0;
        while (nWAIT === 1'b0 && n < 20) begin
            n++;
            step();
            settle();
        end
        chk("slow_wait_len", 16'(n), 16'(WAITS));
        if (!is_wr) chk("slow_read_data", {8'h00, Z80_DIN}, {8'h00, MEM_DOUT});
        for (int i = 0; i < 2; i++) begin
            step(); settle();
            chk("slow_hold_nwait", {15'b0, nWAIT}, 16'h0001);
        end
        step(); bus_idle();
        settle();
        chk("slow_release_nwait", {15'b0, nWAIT}, 16'h0001);
    endtask

    initial begin
        nRESET = 1'b0;
        bus_idle();
        Z80_ADDR = 16'h0000; Z80_DOUT = 8'h00; CMD_DATA = 8'h00; MEM_DOUT = 8'h00;
        m_reset();
        repeat (2) begin step(); settle(); end
        nRESET = 1'b1;
        step(); Z80_ADDR = STATUS_A;
        settle();
        chk("reset_nint", {15'b0, nINT}, 16'h0001);
        chk("reset_nwait", {15'b0, nWAIT}, 16'h0001);
        chk("reset_status", {8'h00, Z80_DIN}, 16'h0000);
        Z80_ADDR = LATCH_A;
        #1 chk("reset_latch", {8'h00, Z80_DIN}, 16'h0000);

        // 1: single command round trip
        host_cmd(8'h5A);
        fast_read(STATUS_A, 1'b0, 8'h00);
        fast_read(LATCH_A, 1'b0, 8'h00);
        chk("t1_nint_cleared", {15'b0, nINT}, 16'h0001);

        // 2: overrun and explicit clear
        host_cmd(8'h11);
        host_cmd(8'h22);
        fast_read(STATUS_A, 1'b0, 8'h00);
        chk("t2_model_status", {14'b0, m_overrun, m_pending}, 16'h0003);
        fast_read(LATCH_A, 1'b0, 8'h00);
        host_cmd(8'h33);
        fast_write(IRQCLR_A, 8'hFF);
        fast_read(STATUS_A, 1'b0, 8'h00);

        // 3: slow read and slow write
        slow_access(1'b0, 16'hC123);
        slow_access(1'b1, 16'hCFFE);

        // 4: host command collides with the latch read
        host_cmd(8'h44);
        fast_read(LATCH_A, 1'b1, 8'h77);
        chk("t4_nint_held", {15'b0, nINT}, 16'h0000);
        fast_read(LATCH_A, 1'b0, 8'h00);

        // 5: reset while the wait is in progress
        host_cmd(8'h99);
        step(); bus_idle();
        Z80_ADDR = 16'hC055; nMREQ = 1'b0; nRD = 1'b0;
        settle();
        chk("t5_wait_started", {15'b0, nWAIT}, 16'h0000);
        step(); nRESET = 1'b0;
        settle();
        m_reset();
        step(); nRESET = 1'b1; Z80_ADDR = STATUS_A;
        settle();
        chk("t5_nwait", {15'b0, nWAIT}, 16'h0001);
        chk("t5_nint", {15'b0, nINT}, 16'h0001);
        chk("t5_status", {8'h00, Z80_DIN}, 16'h0000);
        step(); bus_idle(); settle();

        // 6: long held read clears once; I/O cycles are ignored
        host_cmd(8'hA5);
        step(); bus_idle();
        Z80_ADDR = LATCH_A; nMREQ = 1'b0; nRD = 1'b0;
        settle();
        chk("t6_read_data", {8'h00, Z80_DIN}, {8'h00, m_latch});
        m_pending = 1'b0;
        for (int i = 1; i < 10; i++) begin
            step();
            if (i == 4) begin CMD_WR = 1'b1; CMD_DATA = 8'h3C; end
            else CMD_WR = 1'b0;
            settle();
            if (i == 4) m_cmd(8'h3C);
        end
        chk("t6_nint_held", {15'b0, nINT}, 16'h0000);
        step(); bus_idle(); settle();
        chk("t6_nint_after", {15'b0, nINT}, 16'h0000);
        for (int k = 0; k < 2; k++) begin
            step(); bus_idle();
            Z80_ADDR = (k == 0) ? LATCH_A : 16'hC000;
            nIORQ = 1'b0; nRD = 1'b0;
            settle();
            chk("t6_io_nwait", {15'b0, nWAIT}, 16'h0001);
            step(); settle();
            chk("t6_io_nint", {15'b0, nINT}, 16'h0000);
            step(); bus_idle(); settle();
        end

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0: host_cmd(8'($urandom));
                1: fast_read(LATCH_A, 1'b0, 8'h00);
                2: fast_read(STATUS_A, 1'b0, 8'h00);
                3: fast_write(IRQCLR_A, 8'($urandom));
                4: fast_read(16'($urandom_range(0, 16'h7FFF)), 1'b0, 8'h00);
                default: slow_access(1'($urandom_range(0, 1)),
                                     16'hC000 | 16'($urandom_range(0, 16'h0FFF)));
            endcase
        end
        fast_read(STATUS_A, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
